exec_seq: RTL and testbench
===========================

# exec_seq

Registered, handshaked execute stage for the pipelined RISC-V core, parametrised in data width and extended with the RV32M multiply/divide operations. Single-cycle ALU, shift, compare and branch work completes in one cycle. MUL/DIV-class operations run on an iterative unit and stall the pipeline through valid/ready handshakes. The block sits between decode/operand-forwarding and the memory stage, and drives its results from registers.

## Interface
- `XLEN`, 32: data width; must be a power of two, at least 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width; derived, not overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of any in-flight or held operation.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted when high together with `in_valid`.
- `op`  in  5  operation code (package enum).
- `a`, `b`  in  XLEN  rs1 data; rs2 data or immediate.
- `pc`, `off`  in  XLEN  pc value; branch/memory offset.
- `b_rs1_pc`  in  1  address base: 0 = `a`, 1 = `pc`.
- `bra_c`  in  3  branch condition (RISC-V funct3 coding).
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  downstream consumes the result.
- `res`  out  XLEN  data result.
- `res_bra`  out  1  branch-taken flag.
- `res_brt_dma`  out  XLEN  branch target / data memory address.
- `illegal`  out  1  `op` was undefined or compiled out.
- `busy`  out  1  iterative operation in progress.

## Operation
- FSM states: IDLE, ITER, HOLD.
- `in_ready = !flush && (IDLE || (HOLD && out_ready))`.
- **Accepting a single-cycle op:** `res`, `res_bra`, `res_brt_dma` and `illegal` are registered and the FSM goes to HOLD.
- **Accepting a multi-cycle op:** operands are latched and the FSM goes to ITER. `res_bra` and `res_brt_dma` are computed at accept and held.
- **ITER → HOLD:** when the iteration counter reaches XLEN-1.
- **HOLD:** if `out_ready` and no new accept, go to IDLE. If `out_ready` and a new accept occurs in the same cycle, the new op follows the single-cycle or multi-cycle accept path above.
- **Single-cycle ops:**
  - Arithmetic/compare: ADD, SUB, SLT (signed), SLTU (unsigned), each modulo 2^XLEN.
  - Logic: XOR, OR, AND.
  - Shifts: SLL, SRL, SRA, using `b[SHW-1:0]`.
  - PASSB: `res = b`.
- **Multi-cycle ops:** MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Multiply is radix-2 shift-add on 2·XLEN bits with sign correction.
  - Divide is restoring division, one quotient bit per cycle.
- **Divide special cases** complete on the single-cycle path:
  - Divide by zero: quotient is all ones; remainder is `a`.
  - DIV with most-negative / -1: quotient is most-negative; remainder is 0.
- **Branch conditions** on `a` vs `b`, independent of `op`:
  - 000 EQ; 001 NE; 100 signed LT; 101 signed GE; 110 unsigned LT; 111 unsigned GE.
  - Codes 010 and 011 give `res_bra = 0`.
- **Address:** `res_brt_dma = (b_rs1_pc ? pc : a) + off`, modulo 2^XLEN.
- **Undefined op:** completes as single-cycle with `res = 0`, `illegal = 1`.
- **Flush:** the FSM goes to IDLE and `out_valid` is 0 on the next cycle. The iteration is abandoned and nothing is accepted that cycle. Flush has priority over every other event.

## Timing
- **Reset values:** `out_valid`, `res`, `res_bra`, `res_brt_dma`, `illegal` and `busy` are all 0. State is IDLE, so `in_ready` is 1.
- **Single-cycle latency:** accept at edge N; `out_valid` is high after edge N. With `out_ready` held high, one op completes per cycle.
- **Multi-cycle latency:** accept at edge N; `busy` is high after N. `out_valid` goes high after edge N+XLEN; `in_ready` stays 0 in between.
- Outputs stay stable while `out_valid && !out_ready`.
- Reset asserted mid-iteration clears everything immediately, without waiting for a clock edge.

## Configuration
- **`EXEC_MDU_EN` defined:** the multiply/divide unit is instantiated and the M ops behave as above.
- **Macro undefined:** the M ops take the undefined-op path: one cycle, `res = 0`, `illegal = 1`, `busy` always 0. No ITER state logic is synthesised, and the port list is unchanged.

## Structure
- **Package `exec_pkg`:**
  - `op` enum: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, PASSB=10, MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - `bra_c` constants.
  - FSM state enum.
- **Sub-module `exec_mdu`:** iterative mul/div with start/done, parametrised by XLEN, wrapped under `EXEC_MDU_EN`.

## Test plan
- **After reset:** `in_valid=1`, ADD `a=0xFFFFFFFF`, `b=1`, `out_ready=1` → `res=0` and `out_valid=1` one cycle later; SLTU of the same operands → 0; SLT → 1.
- **Branch:** `bra_c=110`, `a=1`, `b=0xFFFFFFFF` → `res_bra=1`; `bra_c=100`, same operands → 0. `b_rs1_pc=1`, `pc=0x100`, `off=0xFFFFFFFC` → `res_brt_dma=0xFC`.
- **MULH:** `a=0x80000000`, `b=0x80000000` → `res=0x40000000` after 32 cycles, `busy` high throughout, `in_ready` low.
- **Divide special cases:** DIV `0x80000000` / `0xFFFFFFFF` → `0x80000000` in 1 cycle; REMU `7`/`0` → `7`; DIVU `7`/`0` → `0xFFFFFFFF`.
- **Flush mid-iteration:** flush at cycle 10 of DIVU → `out_valid` never rises; `in_ready=1` next cycle. A following ADD `2+3` → `res=5`.
- **Backpressure:** `out_ready=0` for 5 cycles with XOR result `0xA5` → `res` stays `0xA5` and `in_ready=0`. Release → next op accepted in the same cycle; with the macro undefined, MUL → `illegal=1`, `res=0`.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, branch condition codes, FSM states.
package exec_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLT    = 5'd2,
        OP_SLTU   = 5'd3,
        OP_XOR    = 5'd4,
        OP_OR     = 5'd5,
        OP_AND    = 5'd6,
        OP_SLL    = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_PASSB  = 5'd10,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } op_e;

    localparam logic [2:0] BRA_EQ  = 3'b000;
    localparam logic [2:0] BRA_NE  = 3'b001;
    localparam logic [2:0] BRA_LT  = 3'b100;
    localparam logic [2:0] BRA_GE  = 3'b101;
    localparam logic [2:0] BRA_LTU = 3'b110;
    localparam logic [2:0] BRA_GEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/exec_mdu.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, sign applied on the final cycle. Zero divisor / overflow never reach here.
module exec_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_res
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_opnd;
    logic              r_div;
    logic              r_hi;
    logic              r_rem;
    logic              r_neg;

    logic              w_sa;
    logic              w_sb;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_p_mul;
    logic [2*XLEN-1:0] w_p_div;
    logic [2*XLEN-1:0] w_p_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_dres;

    // op[2:0]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
    assign w_sa    = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
    assign w_sb    = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
    assign w_a_neg = w_sa && i_a[XLEN-1];
    assign w_b_neg = w_sb && i_b[XLEN-1];
    assign w_a_abs = w_a_neg ? -i_a : i_a;
    assign w_b_abs = w_b_neg ? -i_b : i_b;

    // Multiply: high half accumulates the multiplicand, low half holds the shifting multiplier.
    assign w_sum   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_p_mul = {w_sum, r_p[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts the quotient in.
    assign w_shift = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_p_div = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_p[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0],  r_p[XLEN-2:0], 1'b1};

    assign w_p_next = r_div ? w_p_div : w_p_mul;
    assign w_prod   = r_neg ? -w_p_next : w_p_next;
    assign w_dres   = r_rem ? w_p_next[2*XLEN-1:XLEN] : w_p_next[XLEN-1:0];

    assign o_done = r_busy && (r_cnt == CNT_LAST);
    assign o_res  = r_div ? (r_neg ? -w_dres : w_dres)
                          : (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_p    <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
            r_hi   <= 1'b0;
            r_rem  <= 1'b0;
            r_neg  <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_div  <= i_op[2];
            r_hi   <= (i_op[1:0] != 2'b00);
            r_rem  <= i_op[2] && i_op[1];
            r_neg  <= (i_op[2] && i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_p    <= {{XLEN{1'b0}}, (i_op[2] ? w_a_abs : w_b_abs)};
            r_opnd <= i_op[2] ? w_b_abs : w_a_abs;
        end else if (r_busy) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_seq.sv
// Registered, handshaked RISC-V execute stage. Define EXEC_MDU_EN to build the
// iterative RV32M unit; otherwise M opcodes complete as illegal in one cycle.
module exec_seq
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] off,
    input  logic            b_rs1_pc,
    input  logic [2:0]      bra_c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            res_bra,
    output logic [XLEN-1:0] res_brt_dma,
    output logic            illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_res;
    logic            r_bra;
    logic [XLEN-1:0] r_brt;
    logic            r_ill;

    logic            w_accept;
    logic            w_multi;
    logic            w_ill;
    logic            w_bra;
    logic [XLEN-1:0] w_brt;
    logic [XLEN-1:0] w_res_sc;
    logic            w_div_zero;
    logic            w_div_ovf;

    assign in_ready    = !flush && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == S_HOLD);
    assign busy        = (r_state == S_ITER);
    assign res         = r_res;
    assign res_bra     = r_bra;
    assign res_brt_dma = r_brt;
    assign illegal     = r_ill;

    assign w_brt      = (b_rs1_pc ? pc : a) + off;
    assign w_div_zero = (b == '0);
    assign w_div_ovf  = (a == MIN_NEG) && (b == ALL_ONES);

    always_comb begin
        w_bra = 1'b0;
        case (bra_c)
            BRA_EQ:  w_bra = (a == b);
            BRA_NE:  w_bra = (a != b);
            BRA_LT:  w_bra = ($signed(a) <  $signed(b));
            BRA_GE:  w_bra = ($signed(a) >= $signed(b));
            BRA_LTU: w_bra = (a <  b);
            BRA_GEU: w_bra = (a >= b);
            default: w_bra = 1'b0;
        endcase
    end

    // Single-cycle result; divide corner cases are resolved here so the MDU never sees them.
    always_comb begin
        w_res_sc = '0;
        w_multi  = 1'b0;
        w_ill    = 1'b0;
        case (op)
            OP_ADD:   w_res_sc = a + b;
            OP_SUB:   w_res_sc = a - b;
            OP_SLT:   w_res_sc = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  w_res_sc = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:   w_res_sc = a ^ b;
            OP_OR:    w_res_sc = a | b;
            OP_AND:   w_res_sc = a & b;
            OP_SLL:   w_res_sc = a << b[SHW-1:0];
            OP_SRL:   w_res_sc = a >> b[SHW-1:0];
            OP_SRA:   w_res_sc = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_PASSB: w_res_sc = b;
`ifdef EXEC_MDU_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_multi = 1'b1;
            OP_DIV, OP_REM: begin
                if (w_div_zero) begin
                    w_res_sc = (op == OP_DIV) ? ALL_ONES : a;
                end else if (w_div_ovf) begin
                    w_res_sc = (op == OP_DIV) ? MIN_NEG : '0;
                end else begin
                    w_multi = 1'b1;
                end
            end
            OP_DIVU, OP_REMU: begin
                if (w_div_zero) begin
                    w_res_sc = (op == OP_DIVU) ? ALL_ONES : a;
                end else begin
                    w_multi = 1'b1;
                end
            end
`endif
            default:  w_ill = 1'b1;
        endcase
    end

`ifdef EXEC_MDU_EN
    logic            w_mdu_done;
    logic [XLEN-1:0] w_mdu_res;

    exec_mdu #(.XLEN(XLEN)) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && w_multi),
        .i_abort (flush),
        .i_op    (op[2:0]),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mdu_done),
        .o_res   (w_mdu_res)
    );
`endif

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_next = w_multi ? S_ITER : S_HOLD;
`ifdef EXEC_MDU_EN
                S_ITER: if (w_mdu_done) w_state_next = S_HOLD;
`endif
                S_HOLD: if (out_ready) w_state_next = w_accept ? (w_multi ? S_ITER : S_HOLD) : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_res   <= '0;
            r_bra   <= 1'b0;
            r_brt   <= '0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_bra <= w_bra;
                r_brt <= w_brt;
                r_ill <= w_ill;
                if (!w_multi) begin
                    r_res <= w_res_sc;
                end
`ifdef EXEC_MDU_EN
            end else if (!flush && (r_state == S_ITER) && w_mdu_done) begin
                r_res <= w_mdu_res;
`endif
            end
        end
    end

endmodule

// File: tb/tb_exec_seq.sv
// Directed self-checking bench for exec_seq; M-unit scenarios follow EXEC_MDU_EN.
module tb_exec_seq;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] off;
    logic        b_rs1_pc;
    logic [2:0]  bra_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        res_bra;
    logic [31:0] res_brt_dma;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    always #5 clk = ~clk;

    exec_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .pc          (pc),
        .off         (off),
        .b_rs1_pc    (b_rs1_pc),
        .bra_c       (bra_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res         (res),
        .res_bra     (res_bra),
        .res_brt_dma (res_brt_dma),
        .illegal     (illegal),
        .busy        (busy)
    );

    task automatic issue(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb);
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        $display("txn op=%0d a=%h b=%h -> ov=%0b res=%h bra=%0b brt=%h ill=%0b busy=%0b",
                 op, a, b, out_valid, res, res_bra, res_brt_dma, illegal, busy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        pc = '0; off = '0; b_rs1_pc = 1'b0; bra_c = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL reset_res got=%h want=0", res); end
        total++; if (res_bra !== 1'b0 || res_brt_dma !== 32'h0) begin bad++; $display("FAIL reset_bra got=%b/%h want=0/0", res_bra, res_brt_dma); end
        total++; if (illegal !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ill_busy got=%b/%b want=0/0", illegal, busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        vec_t tbl [13] = '{
            '{OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        1'b0},
            '{OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0},
            '{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        1'b0},
            '{OP_SUB,   32'h3,        32'h5,        32'hFFFFFFFE, 1'b0},
            '{OP_XOR,   32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0},
            '{OP_OR,    32'hF0,       32'h0F,       32'hFF,       1'b0},
            '{OP_AND,   32'hF0,       32'h3C,       32'h30,       1'b0},
            '{OP_SLL,   32'h1,        32'd33,       32'h2,        1'b0},
            '{OP_SRL,   32'h80000000, 32'd4,        32'h08000000, 1'b0},
            '{OP_SRA,   32'h80000000, 32'd4,        32'hF8000000, 1'b0},
            '{OP_PASSB, 32'h0,        32'h1234,     32'h1234,     1'b0},
            '{5'd11,    32'h7,        32'h7,        32'h0,        1'b1},
            '{OP_ADD,   32'h2,        32'h2,        32'h4,        1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            step();
            total++;
            if (out_valid !== 1'b1 || res !== tbl[i].exp || illegal !== tbl[i].ill) begin
                bad++;
                $display("FAIL alu_%0d op=%0d got ov=%b res=%h ill=%b want ov=1 res=%h ill=%b",
                         i, tbl[i].op, out_valid, res, illegal, tbl[i].exp, tbl[i].ill);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  bc [8]  = '{3'b110, 3'b100, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011};
        logic [31:0] ba [8]  = '{32'h1, 32'h1, 32'h5, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h1};
        logic [31:0] bb [8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h1, 32'h1, 32'h5, 32'h2};
        logic        be [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bra_c = bc[i];
            issue(OP_ADD, ba[i], bb[i]);
            step();
            total++;
            if (res_bra !== be[i]) begin
                bad++;
                $display("FAIL branch_%0d bra_c=%b got=%b want=%b", i, bc[i], res_bra, be[i]);
            end
        end
        b_rs1_pc = 1'b1; pc = 32'h100; off = 32'hFFFFFFFC;
        issue(OP_ADD, 32'h5000, 32'h0);
        step();
        total++; if (res_brt_dma !== 32'hFC) begin bad++; $display("FAIL addr_pc got=%h want=000000fc", res_brt_dma); end
        b_rs1_pc = 1'b0; off = 32'h10;
        issue(OP_ADD, 32'h1000, 32'h0);
        step();
        total++; if (res_brt_dma !== 32'h1010) begin bad++; $display("FAIL addr_rs1 got=%h want=00001010", res_brt_dma); end
        off = 32'h0; bra_c = 3'b000;
    endtask

`ifdef EXEC_MDU_EN
    task automatic test_mdu();
        vec_t tbl [5] = '{
            '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
            '{OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0},
            '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0},
            '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0},
            '{OP_MUL,    32'd6,        32'd7,        32'd42,       1'b0}
        };
        int early;
        for (int i = 0; i < 5; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            step();
            in_valid = 1'b0;
            early = 0;
            for (int k = 1; k < 32; k++) begin
                if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) early++;
                step();
            end
            total++;
            if (early != 0) begin bad++; $display("FAIL mdu_busy_%0d bad_cycles=%0d want=0", i, early); end
            step();
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || res !== tbl[i].exp) begin
                bad++;
                $display("FAIL mdu_res_%0d got ov=%b busy=%b res=%h want ov=1 busy=0 res=%h",
                         i, out_valid, busy, res, tbl[i].exp);
            end
        end
    endtask
`endif

    task automatic test_div_special();
`ifdef EXEC_MDU_EN
        vec_t tbl [4] = '{
            '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0},
            '{OP_REMU, 32'd7,        32'd0,        32'd7,        1'b0},
            '{OP_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0},
            '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0}
        };
`else
        vec_t tbl [4] = '{
            '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1},
            '{OP_REMU, 32'd7,        32'd0,        32'h0, 1'b1},
            '{OP_DIVU, 32'd7,        32'd0,        32'h0, 1'b1},
            '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1}
        };
`endif
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            step();
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || res !== tbl[i].exp || illegal !== tbl[i].ill) begin
                bad++;
                $display("FAIL divspec_%0d got ov=%b busy=%b res=%h ill=%b want ov=1 busy=0 res=%h ill=%b",
                         i, out_valid, busy, res, illegal, tbl[i].exp, tbl[i].ill);
            end
        end
    endtask

    task automatic test_backpressure();
        int moved;
        issue(OP_XOR, 32'hF0, 32'h55);
        step();
        out_ready = 1'b0;
        issue(OP_ADD, 32'h1, 32'h1);
        #1;
        total++; if (res !== 32'hA5 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_start res=%h rdy=%b want a5/0", res, in_ready); end
        moved = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (res !== 32'hA5 || out_valid !== 1'b1 || in_ready !== 1'b0) moved++;
        end
        total++; if (moved != 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d want=0", moved); end
        out_ready = 1'b1;
`ifdef EXEC_MDU_EN
        issue(OP_ADD, 32'h1, 32'h1);
`else
        issue(OP_MUL, 32'h6, 32'h7);
`endif
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        step();
`ifdef EXEC_MDU_EN
        total++; if (out_valid !== 1'b1 || res !== 32'h2 || illegal !== 1'b0) begin bad++; $display("FAIL bp_next got ov=%b res=%h ill=%b want 1/2/0", out_valid, res, illegal); end
`else
        total++; if (out_valid !== 1'b1 || res !== 32'h0 || illegal !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_mul_illegal got ov=%b res=%h ill=%b busy=%b want 1/0/1/0", out_valid, res, illegal, busy); end
`endif
    endtask

    task automatic test_flush();
        int rose;
`ifdef EXEC_MDU_EN
        issue(OP_DIVU, 32'd100, 32'd7);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b want=1", busy); end
`else
        issue(OP_ADD, 32'h9, 32'h9);
        step();
`endif
        flush = 1'b1;
        issue(OP_ADD, 32'h2, 32'h3);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", in_ready); end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_after got ov=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready); end
        rose = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (out_valid !== 1'b0) rose++;
        end
        total++; if (rose != 0) begin bad++; $display("FAIL flush_no_result cycles_valid=%0d want=0", rose); end
        issue(OP_ADD, 32'h2, 32'h3);
        step();
        total++; if (out_valid !== 1'b1 || res !== 32'h5) begin bad++; $display("FAIL flush_next got ov=%b res=%h want 1/5", out_valid, res); end
    endtask

    task automatic test_async_reset();
        issue(OP_ADD, 32'h4, 32'h4);
        step();
`ifdef EXEC_MDU_EN
        issue(OP_DIVU, 32'd99, 32'd5);
        step();
        in_valid = 1'b0;
        step();
`endif
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || res !== 32'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset got ov=%b busy=%b res=%h rdy=%b want 0/0/0/1", out_valid, busy, res, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_div_special();
`ifdef EXEC_MDU_EN
        test_mdu();
`endif
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
